uart_rx_oversampler: RTL
========================

Name: uart_rx_oversampler

Overview:
- Oversampling UART receiver: the front-end stage that deserialises the raw RXD pin and feeds bytes to the uart command/datapath.
- Sits between the top-level pin bundle and the uart core.
- Synchronises RXD, validates the start bit, majority-votes each bit and checks the stop bit.
- Presents each byte through a one-entry valid/ready holding register, with framing and overrun pulses.

Parameters:
- CLK_DIV, 1, clk cycles per oversample tick (>=1).
- OVERSAMPLE, 8, ticks per bit period (even, >=4).
- DATA_BITS, 8, data bits per frame (5..8), LSB first.

Ports:
- clk  input  1  single clock; the entire block is clocked on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rxd  input  1  raw serial line; idles high; asynchronous to clk.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts; transfer when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (async): rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, synchroniser flops=1, all counters=0.
- rxd passes through a 2-flop synchroniser, giving rxd_s. Two cycles of latency; all decisions use rxd_s.
- Tick generator:
  - Counts 0..CLK_DIV-1; tick=1 when it wraps.
  - Restarted on the IDLE->START transition so the phase aligns to the falling edge.
- Phase counter counts ticks 0..OVERSAMPLE-1 within a bit.
- Each bit is sampled at phases M-1, M and M+1, where M=OVERSAMPLE/2. The bit value is the 2-of-3 majority.
- FSM:
  - IDLE: on rxd_s=0, go to START and clear the phase and bit counters.
  - START: at the M+1 vote, majority 0 -> DATA; majority 1 -> IDLE (glitch rejected, no pulse).
  - DATA: shift each voted bit into the shift register, LSB first. After bit DATA_BITS-1 -> STOP.
  - STOP, voted 1: byte complete, go to IDLE immediately (half-bit early, for resync margin).
  - STOP, voted 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rxd_s=1, then IDLE. This covers break conditions: one pulse per break, however long.
- Transitions occur only on tick cycles, except IDLE detection and WAIT_IDLE exit, which act on any clk.
- Delivery:
  - Byte complete in cycle N -> rx_valid=1 and rx_data loaded at edge N+1.
  - If rx_valid=1 and rx_ready=0 in cycle N: the new byte is dropped, rx_data is unchanged, and overrun pulses at N+1.
  - If rx_valid & rx_ready in the same cycle as completion: the old byte transfers and the new byte loads; rx_valid stays 1 and overrun stays 0.
  - Transfer without completion: rx_valid->0 next edge.
- frame_err and overrun never assert in the same cycle as each other's cause.
- A reset mid-frame aborts instantly. The remainder of that frame is seen as line activity: any low level in IDLE starts a new frame attempt.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Enabled:
  - Adds state PARITY between DATA and STOP, plus input parity_odd (1 bit; 0=even, 1=odd).
  - Voted parity is compared against the XOR of the data bits, inverted for odd.
  - Mismatch: adds output parity_err, which pulses one cycle at delivery. The byte is still delivered, or dropped on overrun.
- Disabled: no PARITY state and no parity_odd/parity_err ports. Frame is 1+DATA_BITS+1.

Test Plan:
- Clean frame: defaults, rxd sends 0xA5 at 8 clk/bit, rx_ready=1 -> rx_valid pulses once with rx_data=0xA5, no errors. busy is high from start detection until the stop-bit vote.
- Glitch: rxd low for 2 clk then high -> busy rises and falls, no rx_valid, no frame_err. A following 0x3C frame is received correctly.
- Framing error: 0x55 sent with stop bit 0, line then held low 40 clk -> exactly one frame_err pulse, no rx_valid. After rxd returns high, 0x0F is received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11 with rx_valid=1, and overrun pulses once. Raising rx_ready clears rx_valid next edge.
- Simultaneous accept/complete: 0x11 held, rx_ready=1 exactly on the completion cycle of 0x22 -> rx_valid stays 1, rx_data=0x22, no overrun.
- Reset mid-frame: assert reset during data bit 3 -> all outputs 0 immediately. After release and idle line, 0x81 is received; with UART_RX_PARITY_EN and bad parity, parity_err pulses with 0x81.

Source files
------------

// File: rtl/uart_rx_oversampler.sv
// Oversampling UART receiver: 2-flop sync, start-bit validation, 2-of-3 bit voting, one-entry holding register.
// Optional parity stage (parity_odd in, parity_err out) when UART_RX_PARITY_EN is defined.
module uart_rx_oversampler #(
  parameter int CLK_DIV    = 1,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int M     = OVERSAMPLE / 2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 rxd_meta_q, rxd_s_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_q, parity_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic tick, vote, maj, complete;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));
  assign vote = tick && (phase_q == PH_W'(M + 1));
  // Third sample is the live synchronised level at phase M+1.
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      phase_q      <= '0;
      bit_q        <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    complete     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != S_IDLE && state_q != S_WAIT_IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        phase_d = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_q + PH_W'(1);
        if (phase_q == PH_W'(M - 1)) samp_d[0] = rxd_s_q;
        if (phase_q == PH_W'(M))     samp_d[1] = rxd_s_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d = S_START;
          div_d   = '0;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (vote) state_d = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (vote) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (vote) begin
          parity_bad_d = maj ^ (^shift_q) ^ parity_odd;
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (vote) begin
          if (maj) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A same-cycle accept frees the slot, so the new byte may load.
    if (complete) begin
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_bad_q;
`endif
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
